// File: rtl/conv_pkg.sv
// Shared definitions for the convolution sequencer: FSM encoding, address
// width helpers and the default pipeline latencies of the MAC/post blocks.
package conv_pkg;

   // One-hot sequencer states
   typedef enum logic [3:0] {
      StIdle  = 4'b0001,
      StRun   = 4'b0010,
      StDrain = 4'b0100,
      StDone  = 4'b1000
   } conv_state_e;

   // Width of every loop counter; comfortably above any LeNet dimension
   localparam int unsigned CNT_W = 16;

   // Default latencies shared with the RAM, MAC and bias/ReLU blocks
   localparam int unsigned DEF_RD_LAT   = 2;
   localparam int unsigned DEF_MAC_LAT  = 3;
   localparam int unsigned DEF_POST_LAT = 2;

   // Bits needed to address n locations (at least one bit)
   function automatic int unsigned addr_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Output edge of a valid (unpadded) convolution
   function automatic int unsigned out_dim(input int unsigned in_d, input int unsigned k,
                                           input int unsigned s);
      return (in_d - k) / s + 1;
   endfunction

endpackage

// File: rtl/conv_tag_pipe.sv
// Fixed-depth shift line carrying a valid bit plus a data/tag word.
module conv_tag_pipe #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_valid,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   output logic [W-1:0] o_data
);

   logic [DEPTH-1:0]        r_valid;
   logic [DEPTH-1:0][W-1:0] r_data;

   // Shift valid and data one stage per cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
         r_data  <= '0;
      end else begin
         r_valid[0] <= i_valid;
         r_data[0]  <= i_data;
         for (int i = 1; i < DEPTH; i++) begin
            r_valid[i] <= r_valid[i-1];
            r_data[i]  <= r_data[i-1];
         end
      end
   end

   assign o_valid = r_valid[DEPTH-1];
   assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/conv_ctrl.sv
// Convolution-layer sequencer: walks kx, ky, ic, ox, oy, oc (inner to outer),
// issues weight/feature read addresses and tags each term so the MAC and
// write strobes line up with the RAM and arithmetic pipeline latencies.
module conv_ctrl
   import conv_pkg::*;
#(
   parameter int unsigned K        = 5,
   parameter int unsigned IN_W     = 32,
   parameter int unsigned IN_H     = 32,
   parameter int unsigned IN_CH    = 1,
   parameter int unsigned OUT_CH   = 6,
   parameter int unsigned STRIDE   = 1,
   parameter int unsigned RD_LAT   = DEF_RD_LAT,
   parameter int unsigned MAC_LAT  = DEF_MAC_LAT,
   parameter int unsigned POST_LAT = DEF_POST_LAT,
   localparam int unsigned OUT_W   = out_dim(IN_W, K, STRIDE),
   localparam int unsigned OUT_H   = out_dim(IN_H, K, STRIDE),
   localparam int unsigned WA_W    = addr_w(OUT_CH * IN_CH * K * K),
   localparam int unsigned FA_W    = addr_w(IN_CH * IN_H * IN_W),
   localparam int unsigned OA_W    = addr_w(OUT_CH * OUT_H * OUT_W)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            stall,
   output logic            busy,
   output logic [WA_W-1:0] w_raddr,
   output logic [FA_W-1:0] f_raddr,
   output logic            rd_en,
   output logic            mac_en,
   output logic            mac_clr,
   output logic [OA_W-1:0] o_waddr,
   output logic            o_wr_en,
   output logic            done
);

   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   localparam logic [CNT_W-1:0] KX_MAX  = CNT_W'(K - 1);
   localparam logic [CNT_W-1:0] IC_MAX  = CNT_W'(IN_CH - 1);
   localparam logic [CNT_W-1:0] OX_MAX  = CNT_W'(OUT_W - 1);
   localparam logic [CNT_W-1:0] OY_MAX  = CNT_W'(OUT_H - 1);
   localparam logic [CNT_W-1:0] OC_MAX  = CNT_W'(OUT_CH - 1);
   localparam logic [WA_W-1:0]  WA_ONE  = 1;
   localparam logic [OA_W-1:0]  OA_ONE  = 1;
   localparam logic [FA_W-1:0]  F_ROW   = FA_W'(IN_W);
   localparam logic [FA_W-1:0]  F_HW    = FA_W'(IN_H * IN_W);
   localparam logic [FA_W-1:0]  F_S     = FA_W'(STRIDE);
   localparam logic [FA_W-1:0]  F_SROW  = FA_W'(STRIDE * IN_W);
   localparam logic [7:0]       DR_ONE  = 1;
   localparam logic [7:0]       LAT_TOT = 8'(RD_LAT + MAC_LAT + POST_LAT);

   conv_state_e r_state;
   logic        r_busy, r_done;
   logic [7:0]  r_drain;

   // Loop counters and incremental address bases
   logic [CNT_W-1:0] r_kx, r_ky, r_ic, r_ox, r_oy, r_oc;
   logic [FA_W-1:0]  r_row, r_ch, r_wincol, r_winrow;
   logic [WA_W-1:0]  r_wptr, r_wbase;
   logic [OA_W-1:0]  r_optr;

   // Issue-stage registers
   logic            r_rd_en, r_first, r_last;
   logic [WA_W-1:0] r_w_addr;
   logic [FA_W-1:0] r_f_addr;
   logic [OA_W-1:0] r_iss_oaddr;

   logic w_adv, w_kx_wrap, w_ky_wrap, w_ic_wrap, w_ox_wrap, w_oy_wrap, w_oc_wrap;
   logic w_pix_end, w_term_first, w_term_last;

   assign w_adv        = (r_state == StRun) && !stall;
   assign w_kx_wrap    = (r_kx == KX_MAX);
   assign w_ky_wrap    = (r_ky == KX_MAX);
   assign w_ic_wrap    = (r_ic == IC_MAX);
   assign w_ox_wrap    = (r_ox == OX_MAX);
   assign w_oy_wrap    = (r_oy == OY_MAX);
   assign w_oc_wrap    = (r_oc == OC_MAX);
   assign w_pix_end    = w_kx_wrap && w_ky_wrap && w_ic_wrap;
   assign w_term_first = (r_kx == '0) && (r_ky == '0) && (r_ic == '0);
   assign w_term_last  = w_pix_end && w_ox_wrap && w_oy_wrap && w_oc_wrap;

   // Sequencer FSM with registered busy and done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StIdle;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_drain <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (start) begin
                  r_state <= StRun;
                  r_busy  <= 1'b1;
               end
            end
            StRun: begin
               r_drain <= '0;
               if (w_adv && w_term_last) r_state <= StDrain;
            end
            StDrain: begin
               // Count out the full read+MAC+post latency behind the last term
               if (r_drain == LAT_TOT) begin
                  r_state <= StDone;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_drain <= r_drain + DR_ONE;
               end
            end
            StDone:  r_state <= StIdle;
            default: r_state <= StIdle;
         endcase
      end
   end

   // Nested loop counters; every wrap lands on zero, so a finished run leaves them cleared
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_kx     <= '0;
         r_ky     <= '0;
         r_ic     <= '0;
         r_ox     <= '0;
         r_oy     <= '0;
         r_oc     <= '0;
         r_row    <= '0;
         r_ch     <= '0;
         r_wincol <= '0;
         r_winrow <= '0;
         r_wptr   <= '0;
         r_wbase  <= '0;
         r_optr   <= '0;
      end else if (w_adv) begin
         r_kx <= w_kx_wrap ? '0 : r_kx + CNT_ONE;
         if (w_kx_wrap) begin
            r_ky  <= w_ky_wrap ? '0 : r_ky + CNT_ONE;
            r_row <= w_ky_wrap ? '0 : r_row + F_ROW;
         end
         if (w_kx_wrap && w_ky_wrap) begin
            r_ic <= w_ic_wrap ? '0 : r_ic + CNT_ONE;
            r_ch <= w_ic_wrap ? '0 : r_ch + F_HW;
         end
         if (w_pix_end) begin
            r_ox     <= w_ox_wrap ? '0 : r_ox + CNT_ONE;
            r_wincol <= w_ox_wrap ? '0 : r_wincol + F_S;
            r_optr   <= w_term_last ? '0 : r_optr + OA_ONE;
            // Weights replay per pixel; move to the next filter only when oc advances
            if (w_ox_wrap && w_oy_wrap) begin
               r_wptr  <= w_oc_wrap ? '0 : r_wptr + WA_ONE;
               r_wbase <= w_oc_wrap ? '0 : r_wptr + WA_ONE;
            end else begin
               r_wptr <= r_wbase;
            end
         end else begin
            r_wptr <= r_wptr + WA_ONE;
         end
         if (w_pix_end && w_ox_wrap) begin
            r_oy     <= w_oy_wrap ? '0 : r_oy + CNT_ONE;
            r_winrow <= w_oy_wrap ? '0 : r_winrow + F_SROW;
         end
         if (w_pix_end && w_ox_wrap && w_oy_wrap) begin
            r_oc <= w_oc_wrap ? '0 : r_oc + CNT_ONE;
         end
      end
   end

   // Issue stage: register read strobe, addresses and term tags together
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_en     <= 1'b0;
         r_first     <= 1'b0;
         r_last      <= 1'b0;
         r_w_addr    <= '0;
         r_f_addr    <= '0;
         r_iss_oaddr <= '0;
      end else begin
         r_rd_en <= w_adv;
         r_first <= w_adv && w_term_first;
         r_last  <= w_adv && w_pix_end;
         if (w_adv) begin
            r_w_addr    <= r_wptr;
            r_f_addr    <= r_winrow + r_wincol + r_ch + r_row + FA_W'(r_kx);
            r_iss_oaddr <= r_optr;
         end
      end
   end

   logic            w_mac_valid;
   logic [OA_W+1:0] w_mac_data;
   logic            w_wr_valid;
   logic [OA_W-1:0] w_wr_addr;

   conv_tag_pipe #(
      .DEPTH (RD_LAT),
      .W     (OA_W + 2)
   ) u_mac_pipe (
      .clk     (clk),
      .rst     (rst),
      .i_valid (r_rd_en),
      .i_data  ({r_first, r_last, r_iss_oaddr}),
      .o_valid (w_mac_valid),
      .o_data  (w_mac_data)
   );

   conv_tag_pipe #(
      .DEPTH (MAC_LAT + POST_LAT),
      .W     (OA_W)
   ) u_wr_pipe (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_mac_data[OA_W]),
      .i_data  (w_mac_data[OA_W-1:0]),
      .o_valid (w_wr_valid),
      .o_data  (w_wr_addr)
   );

   assign busy    = r_busy;
   assign done    = r_done;
   assign rd_en   = r_rd_en;
   assign w_raddr = r_w_addr;
   assign f_raddr = r_f_addr;
   assign mac_en  = w_mac_valid;
   assign mac_clr = w_mac_data[OA_W+1];
   assign o_wr_en = w_wr_valid;
   assign o_waddr = w_wr_addr;

endmodule

// File: tb/tb_conv_ctrl.sv
// Self-checking bench for conv_ctrl on a small strided two-channel layer.
module tb_conv_ctrl;

   localparam int K = 3, IN_W = 7, IN_H = 7, IN_CH = 2, OUT_CH = 2, S = 2;
   localparam int RDL = 2, MACL = 3, POSTL = 2;
   localparam int LAT = RDL + MACL + POSTL;
   localparam int OUT_W = (IN_W - K) / S + 1;
   localparam int OUT_H = (IN_H - K) / S + 1;
   localparam int TPP = IN_CH * K * K;                 // terms per pixel
   localparam int NPIX = OUT_CH * OUT_H * OUT_W;
   localparam int N = NPIX * TPP;
   localparam int WA_W = $clog2(OUT_CH * IN_CH * K * K);
   localparam int FA_W = $clog2(IN_CH * IN_H * IN_W);
   localparam int OA_W = $clog2(NPIX);
   localparam int MAXC = 8192;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0, stall = 1'b0;
   logic busy, rd_en, mac_en, mac_clr, o_wr_en, done;
   logic [WA_W-1:0] w_raddr;
   logic [FA_W-1:0] f_raddr;
   logic [OA_W-1:0] o_waddr;

   conv_ctrl #(
      .K(K), .IN_W(IN_W), .IN_H(IN_H), .IN_CH(IN_CH), .OUT_CH(OUT_CH), .STRIDE(S),
      .RD_LAT(RDL), .MAC_LAT(MACL), .POST_LAT(POSTL)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .stall(stall), .busy(busy),
      .w_raddr(w_raddr), .f_raddr(f_raddr), .rd_en(rd_en), .mac_en(mac_en),
      .mac_clr(mac_clr), .o_waddr(o_waddr), .o_wr_en(o_wr_en), .done(done)
   );

   always #5 clk = ~clk;

   int n_checks = 0, n_err = 0;
   int cyc = 0;

   // Reference model: expected strobes indexed by cycle
   bit exp_rd [0:MAXC-1];
   bit exp_mac [0:MAXC-1];
   bit exp_clr [0:MAXC-1];
   bit exp_wr [0:MAXC-1];
   bit exp_done [0:MAXC-1];
   int exp_oa [0:MAXC-1];
   bit m_busy = 0, m_running = 0;
   int m_k = 0, m_done_cyc = -1, m_idle_from = 0, m_stalls = 0;
   int m_w = 0, m_f = 0;

   // Per-run DUT observations
   int o_writes, o_clrs, o_macs, o_first_rd, o_done_at, o_busy_rises;
   bit prev_busy = 0;

   typedef struct {
      int stall_at;
      int stall_len;
      bit rnd_stall;
      bit junk_start;
      int exp_writes;
      int exp_clrs;
      int exp_macs;
      int exp_span;
   } vec_t;

   vec_t tv [5];

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
      end
   endtask

   task automatic mark(input int idx, input int what, input int val);
      if (idx < MAXC) begin
         case (what)
            0: exp_rd[idx] = 1'b1;
            1: exp_mac[idx] = 1'b1;
            2: exp_clr[idx] = 1'b1;
            3: begin exp_wr[idx] = 1'b1; exp_oa[idx] = val; end
            default: exp_done[idx] = 1'b1;
         endcase
      end
   endtask

   // Advance the model by one clock edge given the inputs seen at that edge
   task automatic model_edge(input bit st, input bit sl, input bit r);
      int kx, ky, ic, pix, ox, oy, oc;
      if (r) begin
         m_running = 0; m_busy = 0; m_done_cyc = -1; m_idle_from = 0;
         m_w = 0; m_f = 0;
         for (int j = cyc; j < cyc + 16 && j < MAXC; j++) begin
            exp_rd[j] = 0; exp_mac[j] = 0; exp_clr[j] = 0; exp_wr[j] = 0; exp_done[j] = 0;
         end
         return;
      end
      if (!m_busy && cyc >= m_idle_from && st) begin
         m_busy = 1; m_running = 1; m_k = 0;
      end else if (m_running && sl) begin
         m_stalls++;
      end else if (m_running) begin
         kx = m_k % K;
         ky = (m_k / K) % K;
         ic = (m_k / (K * K)) % IN_CH;
         pix = m_k / TPP;
         ox = pix % OUT_W;
         oy = (pix / OUT_W) % OUT_H;
         oc = pix / (OUT_W * OUT_H);
         m_w = oc * TPP + (m_k % TPP);
         m_f = ic * IN_H * IN_W + (oy * S + ky) * IN_W + ox * S + kx;
         mark(cyc, 0, 0);
         mark(cyc + RDL, 1, 0);
         if (m_k % TPP == 0) mark(cyc + RDL, 2, 0);
         if (m_k % TPP == TPP - 1) mark(cyc + LAT, 3, pix);
         m_k++;
         if (m_k == N) begin
            m_running = 0;
            m_done_cyc = cyc + LAT + 1;
            mark(m_done_cyc, 4, 0);
         end
      end
      if (m_busy && cyc == m_done_cyc) begin
         m_busy = 0;
         m_idle_from = cyc + 2;
      end
   endtask

   task automatic check_cycle();
      chk("rd_en", int'(rd_en), int'(exp_rd[cyc]));
      chk("mac_en", int'(mac_en), int'(exp_mac[cyc]));
      chk("mac_clr", int'(mac_clr), int'(exp_clr[cyc]));
      chk("o_wr_en", int'(o_wr_en), int'(exp_wr[cyc]));
      chk("done", int'(done), int'(exp_done[cyc]));
      chk("busy", int'(busy), int'(m_busy));
      chk("w_raddr", int'(w_raddr), m_w);
      chk("f_raddr", int'(f_raddr), m_f);
      if (exp_wr[cyc]) chk("o_waddr", int'(o_waddr), exp_oa[cyc]);
      if (o_wr_en) o_writes++;
      if (mac_clr) o_clrs++;
      if (mac_en) o_macs++;
      if (rd_en && o_first_rd < 0) o_first_rd = cyc;
      if (done && o_done_at < 0) o_done_at = cyc;
      if (busy && !prev_busy) o_busy_rises++;
      prev_busy = busy;
   endtask

   // Drive inputs (we sit at a falling edge), take one rising edge, check at the next fall
   task automatic step(input bit st, input bit sl);
      start = st;
      stall = sl;
      @(posedge clk);
      cyc++;
      model_edge(st, sl, rst);
      @(negedge clk);
      check_cycle();
   endtask

   task automatic clear_obs();
      o_writes = 0; o_clrs = 0; o_macs = 0; o_first_rd = -1; o_done_at = -1;
      o_busy_rises = 0; m_stalls = 0;
   endtask

   task automatic run_vec(input int i);
      int used;
      bit st, sl;
      used = 0;
      clear_obs();
      step(1'b1, 1'b0);
      for (int c = 0; c < 3000 && o_done_at < 0; c++) begin
         sl = 1'b0;
         if (tv[i].rnd_stall) sl = ($urandom_range(0, 3) == 0);
         else if (m_running && m_k == tv[i].stall_at && used < tv[i].stall_len) begin
            sl = 1'b1;
            used++;
         end
         st = tv[i].junk_start && busy && ($urandom_range(0, 5) == 0);
         step(st, sl);
      end
      if (o_done_at < 0) chk("run_timeout", 0, 1);
      repeat (3) step(1'b0, 1'b0);
      chk("writes", o_writes, tv[i].exp_writes);
      chk("mac_clr_count", o_clrs, tv[i].exp_clrs);
      chk("mac_en_count", o_macs, tv[i].exp_macs);
      chk("busy_intervals", o_busy_rises, 1);
      if (tv[i].rnd_stall) chk("span_rnd", o_done_at - o_first_rd, N + LAT + m_stalls);
      else chk("span", o_done_at - o_first_rd, tv[i].exp_span);
   endtask

   initial begin
      int wr_after;
      //        stall_at len rnd junk writes clrs macs span
      tv[0] = '{-1, 0, 1'b0, 1'b0, NPIX, NPIX, N, N + LAT};
      tv[1] = '{40, 3, 1'b0, 1'b0, NPIX, NPIX, N, N + LAT + 3};
      tv[2] = '{17, 1, 1'b0, 1'b0, NPIX, NPIX, N, N + LAT + 1};
      tv[3] = '{-1, 0, 1'b0, 1'b1, NPIX, NPIX, N, N + LAT};
      tv[4] = '{-1, 0, 1'b1, 1'b1, NPIX, NPIX, N, 0};

      clear_obs();
      @(negedge clk);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);          // start while in reset must be ignored
      rst = 1'b0;
      step(1'b0, 1'b0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_waddr", int'(w_raddr), 0);

      for (int i = 0; i < 5; i++) run_vec(i);

      // Reset in the middle of a run
      clear_obs();
      step(1'b1, 1'b0);
      repeat (100) step(1'b0, 1'b0);
      rst = 1'b1;
      #1;
      chk("async_rst_rd_en", int'(rd_en), 0);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_f_raddr", int'(f_raddr), 0);
      step(1'b0, 1'b0);
      rst = 1'b0;
      wr_after = 0;
      for (int c = 0; c < 20; c++) begin
         step(1'b0, 1'b0);
         if (o_wr_en || done) wr_after++;
      end
      chk("post_reset_quiet", wr_after, 0);
      run_vec(0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
